ring_decoder: RTL and testbench

Receive-side companion to the team's 4-bit one-hot ring counter. Samples a WIDTH-bit one-hot ring word every enabled clock, converts it to a binary position index and checks that successive words follow the ring's rotation order. A lock state machine (UNLOCKED/ACQUIRE/LOCKED) qualifies the sequence. Sequence faults seen while locked are flagged and counted, so downstream logic can trust `idx` only while `locked` is high.

---
 rtl/ring_decoder.sv | 247 ++++++++++++++++++++++++
 tb/tb_ring_decoder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_decoder.sv
// ring_decoder
//   Receive-side checker for a WIDTH-bit one-hot ring counter. On every clock
//   edge with en=1 it samples ring_in, converts a one-hot word to a binary
//   position index and checks that the word follows the ring's rotation order
//   (index+1 mod WIDTH). A lock state machine (UNLOCKED / ACQUIRE / LOCKED)
//   qualifies the sequence. Sequence faults seen while LOCKED raise err_pulse
//   and bump a saturating error counter.
//
// Ports
//   clk        rising-edge clock, the only clock
//   clr_n      asynchronous active-low reset
//   en         sample enable; ring_in is evaluated only on edges with en=1
//   ring_in    WIDTH-bit ring word from the counter
//   idx        position of the last valid one-hot word (hot bit b -> WIDTH-1-b)
//   idx_valid  last sampled word was exactly one-hot
//   locked     sequence lock established
//   wrap       one-cycle pulse: locked, in-order step from WIDTH-1 to 0
//   err_pulse  one-cycle pulse: sequence fault while locked
//   err_cnt    saturating count of err_pulse events (cleared only by reset)
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.

module ring_decoder #(
  parameter  int WIDTH    = 4,
  parameter  int LOCK_CNT = 3,
  parameter  int ERR_W    = 8,
  localparam int IW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic [WIDTH-1:0] ring_in,
  output logic [IW-1:0]    idx,
  output logic             idx_valid,
  output logic             locked,
  output logic             wrap,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt
);

  // good_cnt must be able to hold the value LOCK_CNT itself.
  localparam int GW = $clog2(LOCK_CNT + 1);

  localparam logic [GW-1:0]    GOOD_MAX = GW'(LOCK_CNT);
  localparam logic [GW-1:0]    GOOD_ONE = GW'(32'd1);
  localparam logic [IW-1:0]    IDX_LAST = IW'(WIDTH - 1);
  localparam logic [IW-1:0]    IDX_ONE  = IW'(32'd1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(32'd1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // True when exactly one bit of the word is set.
  function automatic logic is_one_hot(input logic [WIDTH-1:0] w);
    int unsigned n;
    n = 32'd0;
    for (int b = 0; b < WIDTH; b++) begin
      if (w[b]) begin
        n = n + 32'd1;
      end else begin
        n = n;
      end
    end
    return (n == 32'd1);
  endfunction

  // Hot bit at position b maps to index WIDTH-1-b (MSB is position 0).
  // Only meaningful when the word is one-hot.
  function automatic logic [IW-1:0] hot_to_idx(input logic [WIDTH-1:0] w);
    logic [IW-1:0] r;
    r = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (w[b]) begin
        r = IW'(WIDTH - 1 - b);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Successor in rotation order; explicit wrap keeps non-power-of-2 widths right.
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (i == IDX_LAST) begin
      return '0;
    end else begin
      return i + IDX_ONE;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // idx_q doubles as the "previous valid index": both update only on enabled
  // one-hot samples and reset to 0, so a separate prev register would always
  // equal idx_q.
  state_e           state_q,     state_d;
  logic [GW-1:0]    good_cnt_q,  good_cnt_d;
  logic [IW-1:0]    idx_q,       idx_d;
  logic             idx_valid_q, idx_valid_d;
  logic             locked_q,    locked_d;
  logic             wrap_q,      wrap_d;
  logic             err_pulse_q, err_pulse_d;
  logic [ERR_W-1:0] err_cnt_q,   err_cnt_d;

  logic          oh_s;
  logic [IW-1:0] sample_idx_s;
  logic          in_order_s;
  logic [GW-1:0] good_inc_s;

  // Decode the incoming word and compare it with the expected successor.
  always_comb begin
    oh_s         = is_one_hot(ring_in);
    sample_idx_s = hot_to_idx(ring_in);
    in_order_s   = (sample_idx_s == next_idx(idx_q));
    if (good_cnt_q == GOOD_MAX) begin
      good_inc_s = good_cnt_q;
    end else begin
      good_inc_s = good_cnt_q + GOOD_ONE;
    end
  end

  // Next-state logic: lock FSM, index capture, pulses and error counter.
  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    idx_d       = idx_q;
    idx_valid_d = idx_valid_q;
    wrap_d      = 1'b0;
    err_pulse_d = 1'b0;
    err_cnt_d   = err_cnt_q;

    if (en) begin
      idx_valid_d = oh_s;
      if (oh_s) begin
        idx_d = sample_idx_s;
      end else begin
        idx_d = idx_q;
      end

      case (state_q)
        ST_UNLOCKED: begin
          // Any one-hot word starts a new run; order is irrelevant here.
          if (oh_s) begin
            state_d    = ST_ACQUIRE;
            good_cnt_d = GOOD_ONE;
          end else begin
            state_d    = ST_UNLOCKED;
            good_cnt_d = '0;
          end
        end

        ST_ACQUIRE: begin
          if (!oh_s) begin
            state_d    = ST_UNLOCKED;
            good_cnt_d = '0;
          end else if (in_order_s) begin
            good_cnt_d = good_inc_s;
            if (good_inc_s == GOOD_MAX) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_ACQUIRE;
            end
          end else begin
            // Out of order: this word becomes the first of a new run.
            state_d    = ST_ACQUIRE;
            good_cnt_d = GOOD_ONE;
          end
        end

        ST_LOCKED: begin
          if (!oh_s) begin
            err_pulse_d = 1'b1;
            state_d     = ST_UNLOCKED;
            good_cnt_d  = '0;
          end else if (in_order_s) begin
            state_d    = ST_LOCKED;
            good_cnt_d = good_inc_s;
            wrap_d     = (sample_idx_s == '0);
          end else begin
            err_pulse_d = 1'b1;
            state_d     = ST_ACQUIRE;
            good_cnt_d  = GOOD_ONE;
          end
        end

        default: begin
          // Unreachable encoding: fall back to a clean unlocked state.
          state_d    = ST_UNLOCKED;
          good_cnt_d = '0;
        end
      endcase

      if (err_pulse_d && (err_cnt_q != ERR_MAX)) begin
        err_cnt_d = err_cnt_q + ERR_ONE;
      end else begin
        err_cnt_d = err_cnt_q;
      end
    end else begin
      // Disabled edge: everything holds, pulses stay low.
      wrap_d      = 1'b0;
      err_pulse_d = 1'b0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // All state and output registers, cleared asynchronously by clr_n.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_UNLOCKED;
      good_cnt_q  <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      wrap_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      locked_q    <= locked_d;
      wrap_q      <= wrap_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign idx       = idx_q;
  assign idx_valid = idx_valid_q;
  assign locked    = locked_q;
  assign wrap      = wrap_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ring_decoder.sv
// tb_ring_decoder
//   Directed table of vectors for the clean lock / fault / enable-gating
//   sequence, hand-written async-reset and saturation sequences, then
//   randomized stimulus checked against a run-length reference model.

module tb_ring_decoder;

  localparam int WIDTH    = 4;
  localparam int LOCK_CNT = 3;

  logic       clk;
  logic       clr_n;
  logic       en;
  logic [3:0] ring_in;
  logic [1:0] idx;
  logic       idx_valid, locked, wrap, err_pulse;
  logic [7:0] err_cnt;

  // Second instance with a 2-bit error counter for the saturation check.
  logic       en2;
  logic [3:0] ring2;
  logic [1:0] idx2;
  logic       idx_valid2, locked2, wrap2, err_pulse2;
  logic [1:0] err_cnt2;

  ring_decoder #(.WIDTH(4), .LOCK_CNT(3), .ERR_W(8)) u_dut (
    .clk(clk), .clr_n(clr_n), .en(en), .ring_in(ring_in),
    .idx(idx), .idx_valid(idx_valid), .locked(locked), .wrap(wrap),
    .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  ring_decoder #(.WIDTH(4), .LOCK_CNT(3), .ERR_W(2)) u_sat (
    .clk(clk), .clr_n(clr_n), .en(en2), .ring_in(ring2),
    .idx(idx2), .idx_valid(idx_valid2), .locked(locked2), .wrap(wrap2),
    .err_pulse(err_pulse2), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // run = length of the current chain of consecutive in-order one-hot
  // samples (0 = no chain); the decoder is locked while run >= LOCK_CNT.
  int m_run, m_last, m_idx, m_valid, m_wrap, m_err, m_cnt;

  task automatic model_reset();
    m_run = 0; m_last = 0; m_idx = 0; m_valid = 0;
    m_wrap = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic e, input logic [3:0] w);
    bit was_locked, oh, inord;
    int p;
    m_wrap = 0;
    m_err  = 0;
    if (e) begin
      was_locked = (m_run >= LOCK_CNT);
      oh = ($countones(w) == 1);
      m_valid = oh;
      if (oh) begin
        p = WIDTH - 1 - $clog2(w);
        inord = (p == (m_last + 1) % WIDTH);
        if (m_run > 0 && inord) m_run = (m_run + 1 > LOCK_CNT) ? LOCK_CNT : m_run + 1;
        else m_run = 1;
        if (was_locked && !inord) m_err = 1;
        if (was_locked && inord && p == 0) m_wrap = 1;
        m_last = p;
        m_idx  = p;
      end else begin
        if (was_locked) m_err = 1;
        m_run = 0;
      end
      if (m_err != 0 && m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " idx"},       int'(idx),       m_idx);
    chk({tag, " idx_valid"}, int'(idx_valid), m_valid);
    chk({tag, " locked"},    int'(locked),    (m_run >= LOCK_CNT) ? 1 : 0);
    chk({tag, " wrap"},      int'(wrap),      m_wrap);
    chk({tag, " err_pulse"}, int'(err_pulse), m_err);
    chk({tag, " err_cnt"},   int'(err_cnt),   m_cnt);
  endtask

  task automatic step(input logic e, input logic [3:0] w);
    en = e;
    ring_in = w;
    @(posedge clk);
    #1;
  endtask

  task automatic sat_step(input logic e, input logic [3:0] w);
    en2 = e;
    ring2 = w;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       en;
    logic [3:0] ring;
    logic [1:0] idx;
    logic       valid;
    logic       locked;
    logic       wrap;
    logic       err;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[21];

  initial begin
    tbl[0]  = '{1'b1, 4'b1000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1, 4'b0100, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 4'b0010, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 4'b0001, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 4'b1000, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 4'b0110, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
    tbl[6]  = '{1'b1, 4'b0100, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[7]  = '{1'b1, 4'b0010, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[8]  = '{1'b1, 4'b0001, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[9]  = '{1'b1, 4'b1000, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1};
    tbl[10] = '{1'b1, 4'b0100, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[11] = '{1'b1, 4'b0001, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
    tbl[12] = '{1'b1, 4'b1000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2};
    tbl[13] = '{1'b1, 4'b0100, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[14] = '{1'b0, 4'b1111, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[15] = '{1'b0, 4'b0000, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[16] = '{1'b0, 4'b0011, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[17] = '{1'b0, 4'b1010, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[18] = '{1'b0, 4'b0001, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[19] = '{1'b1, 4'b0010, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[20] = '{1'b1, 4'b0001, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] w;
    clr_n = 1'b0; en = 1'b0; ring_in = 4'b0000;
    en2 = 1'b0; ring2 = 4'b0000;
    #12;
    chk("rst idx",       int'(idx),       0);
    chk("rst idx_valid", int'(idx_valid), 0);
    chk("rst locked",    int'(locked),    0);
    chk("rst wrap",      int'(wrap),      0);
    chk("rst err_pulse", int'(err_pulse), 0);
    chk("rst err_cnt",   int'(err_cnt),   0);
    #10 clr_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table.
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].en, tbl[i].ring);
      chk($sformatf("tbl%0d idx", i),       int'(idx),       int'(tbl[i].idx));
      chk($sformatf("tbl%0d idx_valid", i), int'(idx_valid), int'(tbl[i].valid));
      chk($sformatf("tbl%0d locked", i),    int'(locked),    int'(tbl[i].locked));
      chk($sformatf("tbl%0d wrap", i),      int'(wrap),      int'(tbl[i].wrap));
      chk($sformatf("tbl%0d err_pulse", i), int'(err_pulse), int'(tbl[i].err));
      chk($sformatf("tbl%0d err_cnt", i),   int'(err_cnt),   int'(tbl[i].cnt));
    end

    // Async reset between edges while locked with err_cnt=2.
    en = 1'b0;
    #2 clr_n = 1'b0;
    #1;
    chk("arst idx",       int'(idx),       0);
    chk("arst idx_valid", int'(idx_valid), 0);
    chk("arst locked",    int'(locked),    0);
    chk("arst err_cnt",   int'(err_cnt),   0);
    chk("arst wrap",      int'(wrap),      0);
    chk("arst err_pulse", int'(err_pulse), 0);
    #2 clr_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 4'b1000); chk("relock e1", int'(locked), 0);
    step(1'b1, 4'b0100); chk("relock e2", int'(locked), 0);
    step(1'b1, 4'b0010); chk("relock e3", int'(locked), 1);
    chk("relock idx", int'(idx), 2);

    // Pulse in flight cleared by reset: fault while locked, reset before next edge.
    step(1'b1, 4'b0000);
    chk("pulse pre-rst", int'(err_pulse), 1);
    en = 1'b0;
    clr_n = 1'b0;
    #1;
    chk("pulse rst err_pulse", int'(err_pulse), 0);
    chk("pulse rst err_cnt",   int'(err_cnt),   0);
    #2 clr_n = 1'b1;
    @(posedge clk);
    #1;

    // Saturation on the 2-bit counter instance.
    for (int k = 0; k < 5; k++) begin
      sat_step(1'b1, 4'b1000);
      sat_step(1'b1, 4'b0100);
      sat_step(1'b1, 4'b0010);
      chk($sformatf("sat%0d locked", k), int'(locked2), 1);
      sat_step(1'b1, 4'b0000);
      chk($sformatf("sat%0d err_pulse", k), int'(err_pulse2), 1);
      chk($sformatf("sat%0d err_cnt", k),   int'(err_cnt2), (k < 3) ? k + 1 : 3);
    end
    en2 = 1'b0;

    // Randomized run against the reference model, starting from reset.
    clr_n = 1'b0;
    #1;
    model_reset();
    check_model("rnd-rst");
    #2 clr_n = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 600; n++) begin
      int r;
      logic e;
      r = $urandom_range(0, 99);
      if (r < 75) begin
        w = 4'b1000 >> ((m_last + 1) % WIDTH);
      end else if (r < 85) begin
        w = 4'b0000;
      end else begin
        w = 4'($urandom_range(0, 15));
      end
      e = ($urandom_range(0, 9) != 0);
      step(e, w);
      model_step(e, w);
      check_model($sformatf("rnd%0d", n));
      if (n == 300) begin
        #2 clr_n = 1'b0;
        #1;
        model_reset();
        check_model("rnd-midrst");
        #2 clr_n = 1'b1;
        @(posedge clk);
        #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
